seq_div_8bit: RTL
=================

Name: seq_div_8bit

Overview:
- Sequential radix-2 restoring divider. It is the inverse datapath of the team's sequential Booth multiplier.
- Takes an 8-bit dividend and divisor, either signed or unsigned, and produces quotient and remainder after a fixed latency.
- Uses a start/busy/rdy handshake. Sits beside the multiplier in the arithmetic unit and feeds the same result mux.

Parameters:
- WIDTH, 8, operand/result width in bits (must be >= 2).
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- sgn  input  1  1 = two's-complement signed divide, 0 = unsigned; sampled with start.
- a  input  WIDTH  dividend; sampled with start.
- b  input  WIDTH  divisor; sampled with start.
- q  output  WIDTH  quotient (registered).
- r  output  WIDTH  remainder (registered).
- rdy  output  1  result valid; level signal.
- busy  output  1  operation in progress.
- dz  output  1  divide-by-zero flag for the last result.
- ovf  output  1  signed overflow flag (MIN / -1) for the last result.

Behaviour:
- Reset (reset_n low, asynchronous):
  - q=0, r=0, rdy=0, busy=0, dz=0, ovf=0; state=IDLE; counter=0; internal registers=0.
  - Reset mid-operation aborts the operation; no partial result is ever presented.
- States: IDLE -> CALC -> FIX -> DONE -> (IDLE or CALC).
- IDLE/DONE, start=1 (accept edge):
  - Latch |a| and |b| (plain values when sgn=0).
  - Latch sign_q = a_msb ^ b_msb and sign_r = a_msb, both only when sgn=1.
  - Latch dz = (b==0) and ovf = sgn & (a==MIN) & (b==all ones).
  - Clear rdy, set busy, counter=0, partial remainder=0; go to CALC.
- CALC, one iteration per cycle, WIDTH cycles:
  - {rem,dvd} <= {rem,dvd} << 1.
  - If shifted rem >= |b|: rem -= |b| and set quotient bit (dvd lsb) to 1.
  - Comparison is WIDTH+1 bits wide so |MIN| = 2^(WIDTH-1) is handled.
  - Go to FIX when counter reaches WIDTH-1.
- FIX, one cycle; writes q and r, sets rdy=1, clears busy; goes to DONE.
  - dz=1: q = all ones, r = a (raw input value), for both sgn settings.
  - ovf=1: q = MIN (0x80), r = 0.
  - Otherwise: q = sign_q ? -quot : quot, and r = sign_r ? -rem : rem. Division truncates toward zero; the remainder takes the dividend's sign.
- DONE: rdy, q, r, dz and ovf hold until the next accepted start. rdy deasserts on that accept edge.
- Latency is fixed and independent of operands, including the dz/ovf cases. The accept edge is cycle 0; rdy=1 and results are visible after edge WIDTH+1, i.e. 10 cycles for WIDTH=8.
- Back-to-back: start may be high in the first DONE cycle and is accepted there.
- start while busy=1 is ignored: no queueing, operands not resampled.
- Changes on a, b or sgn while busy have no effect.
- q and r keep their previous values through CALC; only FIX updates them.

Decomposition:
- Shared package arith_pkg:
  - state enum {IDLE, CALC, FIX, DONE}.
  - DIV_WIDTH default of 8.
  - DIV_LATENCY = DIV_WIDTH+2.
  - Helper function for signed magnitude (abs with MIN handling), also usable by the Booth multiplier.
- One natural sub-module: div_step. It is combinational: it takes rem, dvd and divisor and returns next rem, next dvd and the quotient bit. It is instantiated once in the top.
- The FSM, counter, sign fix-up and output registers live in the top module.

Test Plan:
- sgn=1, a=100, b=7, start pulse -> busy=1 for 9 cycles, then rdy=1 with q=14 (0x0E), r=2, dz=0, ovf=0 at cycle 10.
- sgn=1, a=-100 (0x9C), b=7 -> q=0xF2 (-14), r=0xFE (-2).
- sgn=0, a=200 (0xC8), b=3 -> q=66 (0x42), r=2. Repeat with sgn=1 -> q=0xEE (-18), r=0xFE (-2).
- a=0x55, b=0, both sgn values -> q=0xFF, r=0x55, dz=1 after the same 10 cycles. Then sgn=1, a=0x80, b=0xFF -> q=0x80, r=0, ovf=1, dz=0.
- Start 100/7; pulse start again with 50/5 at cycle 3 -> ignored; result is still 14 r 2. Issue 50/5 in the first DONE cycle -> rdy drops on that edge, and q=10, r=0 appears 10 cycles later.
- Start 100/7, drive reset_n low at cycle 4 -> all outputs 0 immediately (asynchronous). Release reset, start 9/2 -> q=4, r=1 after 10 cycles.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: divider FSM states, widths and a
// sign/magnitude helper usable by both the divider and the Booth multiplier.
package arith_pkg;

    localparam int unsigned DIV_WIDTH   = 8;
    localparam int unsigned DIV_LATENCY = DIV_WIDTH + 2;
    localparam int unsigned MAG_W       = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Conditional two's-complement negate on a zero-extended operand; callers
    // truncate back to their width, so |MIN| comes out as 2^(W-1) unsigned.
    function automatic logic [MAG_W-1:0] sgn_mag(input logic [MAG_W-1:0] x,
                                                 input logic             neg);
        sgn_mag = neg ? (~x + MAG_W'(1)) : x;
    endfunction

endpackage

// File: rtl/seq_div_8bit_div_step.sv
// One radix-2 restoring iteration: shift {rem,dvd} left, trial-subtract the
// divisor with a WIDTH+1 bit compare; the top inserts the quotient bit.
module div_step
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] dvd,
    input  logic [WIDTH-1:0] dsr,
    output logic [WIDTH-1:0] rem_nxt_c,
    output logic [WIDTH-1:0] dvd_nxt_c,
    output logic             q_bit_c
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // The true difference is always below the divisor, so the low WIDTH bits suffice.
    always_comb begin
        shifted   = {rem, dvd[WIDTH-1]};
        diff      = shifted[WIDTH-1:0] - dsr;
        q_bit_c   = (shifted >= {1'b0, dsr});
        rem_nxt_c = q_bit_c ? diff : shifted[WIDTH-1:0];
        dvd_nxt_c = {dvd[WIDTH-2:0], 1'b0};
    end

endmodule

// File: rtl/seq_div_8bit.sv
// Sequential signed/unsigned restoring divider with start/busy/rdy handshake
// and fixed WIDTH+2 cycle latency, including divide-by-zero and overflow cases.
module seq_div_8bit
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             rdy,
    output logic             busy,
    output logic             dz,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] rem, rem_n;
    logic [WIDTH-1:0] dvd, dvd_n;
    logic [WIDTH-1:0] dsr, dsr_n;
    logic [WIDTH-1:0] a_raw, a_raw_n;
    logic             sign_q, sign_q_n;
    logic             sign_r, sign_r_n;
    logic             dz_n, ovf_n, rdy_n, busy_n;
    logic [WIDTH-1:0] q_n, r_n;

    logic [WIDTH-1:0] step_rem_c, step_dvd_c;
    logic             step_qbit_c;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem       (rem),
        .dvd       (dvd),
        .dsr       (dsr),
        .rem_nxt_c (step_rem_c),
        .dvd_nxt_c (step_dvd_c),
        .q_bit_c   (step_qbit_c)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            rem    <= '0;
            dvd    <= '0;
            dsr    <= '0;
            a_raw  <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            dz     <= 1'b0;
            ovf    <= 1'b0;
            q      <= '0;
            r      <= '0;
            rdy    <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            rem    <= rem_n;
            dvd    <= dvd_n;
            dsr    <= dsr_n;
            a_raw  <= a_raw_n;
            sign_q <= sign_q_n;
            sign_r <= sign_r_n;
            dz     <= dz_n;
            ovf    <= ovf_n;
            q      <= q_n;
            r      <= r_n;
            rdy    <= rdy_n;
            busy   <= busy_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        rem_n    = rem;
        dvd_n    = dvd;
        dsr_n    = dsr;
        a_raw_n  = a_raw;
        sign_q_n = sign_q;
        sign_r_n = sign_r;
        dz_n     = dz;
        ovf_n    = ovf;
        q_n      = q;
        r_n      = r;
        rdy_n    = rdy;
        busy_n   = busy;

        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    dvd_n    = WIDTH'(sgn_mag(MAG_W'(a), sgn & a[WIDTH-1]));
                    dsr_n    = WIDTH'(sgn_mag(MAG_W'(b), sgn & b[WIDTH-1]));
                    a_raw_n  = a;
                    sign_q_n = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                    sign_r_n = sgn & a[WIDTH-1];
                    dz_n     = (b == '0);
                    ovf_n    = sgn & (a == MIN_VAL) & (b == '1);
                    rem_n    = '0;
                    cnt_n    = '0;
                    rdy_n    = 1'b0;
                    busy_n   = 1'b1;
                    state_n  = CALC;
                end
            end
            CALC: begin
                rem_n = step_rem_c;
                dvd_n = step_dvd_c | WIDTH'(step_qbit_c);
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_n = FIX;
                end
            end
            FIX: begin
                if (dz) begin
                    q_n = '1;
                    r_n = a_raw;
                end else if (ovf) begin
                    q_n = MIN_VAL;
                    r_n = '0;
                end else begin
                    q_n = WIDTH'(sgn_mag(MAG_W'(dvd), sign_q));
                    r_n = WIDTH'(sgn_mag(MAG_W'(rem), sign_r));
                end
                rdy_n   = 1'b1;
                busy_n  = 1'b0;
                state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
